// File: rtl/reg_file_sb.sv
// Decode-stage register file: two combinational read ports, one writeback port,
// optional write-to-read bypass, hardwired zero register and a busy scoreboard.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write_i,
  input  logic [SIZE-1:0]  write_register_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic [SIZE-1:0]  read_register_1_i,
  input  logic [SIZE-1:0]  read_register_2_i,
  output logic [WIDTH-1:0] read_data_1_o,
  output logic [WIDTH-1:0] read_data_2_o,
  input  logic             mark_busy_i,
  input  logic [SIZE-1:0]  mark_register_i,
  output logic             busy_1_o,
  output logic             busy_2_o,
  output logic [SIZE:0]    busy_count_o
);

  localparam int NREG = 2 ** SIZE;
  localparam int CW   = SIZE + 1;

  logic [WIDTH-1:0] mem_q [NREG];
  logic [NREG-1:0]  busy_q;
  logic [CW-1:0]    count_q;

  logic wr_ok;
  logic mk_ok;
  logic set_eff;
  logic clr_eff;

  // NOTE: every variable gets a value at the top of an always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ok   = reg_write_i && !(ZERO_REG && write_register_i == '0);
    mk_ok   = mark_busy_i && !(ZERO_REG && mark_register_i == '0);
    set_eff = mk_ok && !busy_q[mark_register_i];
    // A same-cycle mark of the writeback target hands the register to the new
    // producer, so the old producer's writeback must not clear it.
    clr_eff = wr_ok && busy_q[write_register_i]
              && !(mark_busy_i && mark_register_i == write_register_i);
  end

  // NOTE: the storage array is reset along with the scoreboard because reads
  // must return 0 after reset; this rules out a plain RAM macro for mem_q.
  // NOTE: all sequential state uses non-blocking assignments so every update
  // below sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok)   mem_q[write_register_i] <= write_data_i;
      if (clr_eff) busy_q[write_register_i] <= 1'b0;
      if (set_eff) busy_q[mark_register_i]  <= 1'b1;
      // set_eff and clr_eff only fire on real busy-bit transitions, so the
      // count tracks the popcount exactly and can never wrap.
      count_q <= count_q + CW'(set_eff) - CW'(clr_eff);
    end
  end

  logic [SIZE-1:0]  rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];
  logic             rd_busy [2];

  assign rd_addr[0] = read_register_1_i;
  assign rd_addr[1] = read_register_2_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (reset && !(ZERO_REG && rd_addr[p] == '0)) begin
        // A forwarded writeback carries valid data, so the reader sees the
        // register as not busy even if it is being re-marked this cycle.
        if (BYPASS && wr_ok && write_register_i == rd_addr[p]) begin
          rd_data[p] = write_data_i;
          rd_busy[p] = 1'b0;
        end else begin
          rd_data[p] = mem_q[rd_addr[p]];
          rd_busy[p] = busy_q[rd_addr[p]];
        end
      end
    end
  end

  assign read_data_1_o = rd_data[0];
  assign read_data_2_o = rd_data[1];
  assign busy_1_o      = rd_busy[0];
  assign busy_2_o      = rd_busy[1];
  assign busy_count_o  = count_q;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard for long-latency producers such as loads and multi-cycle ALU ops. It sits in the decode stage in place of the fixed 32x32 register file. It lets decode read operands and detect RAW hazards in the same cycle. Storage is one flat behavioural array; there is no per-register instance fabric.

## Interface
- WIDTH, 32, data width in bits
- SIZE, 5, address width; the file holds 2**SIZE registers
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, when 1, a same-cycle write is forwarded to the read ports and clears busy combinationally

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- reg_write_i  in  1  writeback enable
- write_register_i  in  SIZE  writeback address (rd)
- write_data_i  in  WIDTH  writeback data
- read_register_1_i  in  SIZE  read address, port 1 (rs)
- read_register_2_i  in  SIZE  read address, port 2 (rt)
- read_data_1_o  out  WIDTH  R[rs]
- read_data_2_o  out  WIDTH  R[rt]
- mark_busy_i  in  1  issue of a long-latency producer
- mark_register_i  in  SIZE  destination register being marked busy
- busy_1_o  out  1  rs has an outstanding producer
- busy_2_o  out  1  rt has an outstanding producer
- busy_count_o  out  SIZE+1  number of registers currently busy

## Operation
- One clock, clk. Reset is asynchronous and active-low, named reset.
- **Write:** at the clk rising edge, if reg_write_i is 1, the register at write_register_i takes write_data_i.
  - Address 0 is ignored when ZERO_REG=1.
- **Read:** combinational from the addresses.
  - Address 0 returns 0 when ZERO_REG=1.
- **Bypass (BYPASS=1):** if reg_write_i is 1, write_register_i equals the read address, and the address is a writable register, the port returns write_data_i instead of the stored value.
  - With BYPASS=0 the port returns the stored value; the new value is visible the cycle after the write.
- **Scoreboard:** one busy bit per register, all 0 after reset. At each clk edge:
  - set_eff = mark_busy_i & (mark_register_i writable) & !busy[mark_register_i]
  - clr_eff = reg_write_i & (write_register_i writable) & busy[write_register_i] & !(mark_busy_i & mark_register_i == write_register_i)
  - busy[mark_register_i] is set when mark_busy_i is 1 and the address is writable.
  - busy[write_register_i] is cleared on a writeback, unless the same register is marked in the same cycle. In that case set wins and the register stays busy for the new producer.
- **busy_n_o:**
  - busy_n_o = busy[addr], with address 0 gated to 0 when ZERO_REG=1.
  - With BYPASS=1 it is also forced to 0 when a clearing writeback to that address occurs in the same cycle. A simultaneous mark of the same register does not re-assert it, because the forwarded data is valid for the current reader.
- **busy_count_o:**
  - busy_count_o next = busy_count_o + set_eff - clr_eff.
  - It never wraps: the maximum is 2**SIZE - ZERO_REG, the minimum is 0.
  - A writeback to a non-busy register leaves the count unchanged.
  - Marking an already-busy register leaves the count unchanged.

## Timing
- Reset (reset=0, asynchronous):
  - All registers, busy bits and busy_count_o go to 0 immediately.
  - read_data_n_o and busy_n_o are forced to 0 while reset=0, bypass included.
  - Writes and marks are ignored while reset=0.
- First edge that acts on inputs: the first rising clk edge after reset deasserts.
- Latency:
  - Read: 0 cycles (combinational).
  - Write to read, BYPASS=1: 0 cycles. BYPASS=0: 1 cycle.
  - Mark to busy_n_o: 1 cycle.
  - Writeback to busy clear: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Count update: 1 cycle after the edge.
- Reset asserted mid-write: the write is lost and the register reads 0.

## Test plan
1. Reset, then read every address on both ports -> all 0, busy_1_o = busy_2_o = 0, busy_count_o = 0.
2. Write R5 = 0xDEADBEEF, with rs=5 in the same cycle:
   - BYPASS=1 -> read_data_1_o = 0xDEADBEEF that cycle.
   - BYPASS=0 -> 0 that cycle, 0xDEADBEEF the next cycle.
3. ZERO_REG=1: write R0 = 0x12345678 and mark R0 -> read_data_1_o = 0, busy_1_o = 0, busy_count_o = 0.
4. Mark R3, then R7, then R3 again -> busy_count_o goes 1, 2, 2. Writeback R3 -> count 1; busy_1_o for rs=3 drops in the writeback cycle (BYPASS=1).
5. Same-cycle mark R9 and writeback R9 while R9 is busy -> R9 takes the new data, R9 stays busy, count unchanged, busy_1_o = 0 that cycle only.
6. Mark all 31 writable registers (SIZE=5) -> busy_count_o = 31. Writeback to non-busy R0 -> no change. Assert reset mid-sequence -> count, busy bits and data are all 0 immediately.
